// File: rtl/dense_layer_parallel.sv
// Dense (fully connected) int8 layer with LANES parallel MAC lanes.
// Channels are processed in groups of LANES; results stream out one lane per beat.
module dense_layer_parallel #(
    parameter int MAX_IN  = 256,
    parameter int MAX_OUT = 64,
    parameter int LANES   = 4,
    localparam int IW  = $clog2(MAX_IN + 1),
    localparam int OW  = $clog2(MAX_OUT + 1),
    localparam int TAW = $clog2(MAX_IN),
    localparam int WAW = $clog2(MAX_IN * MAX_OUT / LANES),
    localparam int BAW = $clog2(MAX_OUT / LANES),
    localparam int CW  = $clog2(MAX_OUT),
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  relu_en,
    input  logic [IW-1:0]         input_size,
    input  logic [OW-1:0]         output_size,
    output logic [TAW-1:0]        tensor_ram_addr,
    output logic                  tensor_ram_re,
    input  logic [7:0]            tensor_ram_dout,
    output logic [WAW-1:0]        weight_rom_addr,
    output logic                  weight_rom_re,
    input  logic [8*LANES-1:0]    weight_rom_dout,
    output logic [BAW-1:0]        bias_rom_addr,
    output logic                  bias_rom_re,
    input  logic [32*LANES-1:0]   bias_rom_dout,
    output logic [31:0]           out_data,
    output logic [CW-1:0]         out_channel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_STREAM,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IW-1:0]      in_len;
    logic [OW-1:0]      out_len;
    logic               relu_q;
    logic [BAW-1:0]     group;
    logic [LW-1:0]      lane;
    logic [TAW-1:0]     t_addr;
    logic [WAW-1:0]     w_addr;
    logic [WAW-1:0]     w_base;
    logic [CW-1:0]      chan_base;
    logic [OW-1:0]      rem;
    logic signed [31:0] acc [LANES];
    logic signed [15:0] prod [LANES];

    logic sizes_ok;
    logic last_rd;
    logic last_lane;
    logic more;
    logic first;
    logic mac;

    assign sizes_ok  = (input_size != '0) && (output_size != '0);
    assign last_rd   = (IW'(t_addr) == in_len - IW'(1));
    assign chan_base = CW'(group) << $clog2(LANES);
    assign rem       = out_len - OW'(chan_base);
    assign last_lane = (OW'(lane) + OW'(1) == rem) ||
                       (lane == LW'(LANES - 1));
    assign more      = rem > OW'(LANES);

    // The address is zeroed on entry to STREAM, so address 0 marks the bias load.
    assign first = (state == S_STREAM) && (t_addr == '0);
    assign mac   = ((state == S_STREAM) && (t_addr != '0)) ||
                   (state == S_DRAIN);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod[l] = 16'($signed(tensor_ram_dout)) *
                      16'($signed(weight_rom_dout[8*l +: 8]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = sizes_ok ? S_BIAS : S_DONE;
                end
            end
            S_BIAS: begin
                state_nx = S_STREAM;
            end
            S_STREAM: begin
                if (last_rd) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nx = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready && last_lane) begin
                    state_nx = more ? S_BIAS : S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_len  <= '0;
            out_len <= '0;
            relu_q  <= 1'b0;
            group   <= '0;
            lane    <= '0;
            t_addr  <= '0;
            w_addr  <= '0;
            w_base  <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc[l] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && sizes_ok) begin
                        in_len  <= input_size;
                        out_len <= output_size;
                        relu_q  <= relu_en;
                        group   <= '0;
                        w_base  <= '0;
                    end
                end
                S_BIAS: begin
                    t_addr <= '0;
                    w_addr <= w_base;
                end
                S_STREAM: begin
                    if (!last_rd) begin
                        t_addr <= t_addr + TAW'(1);
                        w_addr <= w_addr + WAW'(1);
                    end
                end
                S_DRAIN: begin
                    lane <= '0;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (!last_lane) begin
                            lane <= lane + LW'(1);
                        end else if (more) begin
                            group  <= group + BAW'(1);
                            w_base <= w_base + WAW'(in_len);
                        end
                    end
                end
                default: begin
                end
            endcase

            // Bias read in BIAS lands now; later cycles accumulate the prior read.
            for (int l = 0; l < LANES; l++) begin
                if (first) begin
                    acc[l] <= bias_rom_dout[32*l +: 32];
                end else if (mac) begin
                    acc[l] <= acc[l] + 32'(prod[l]);
                end
            end
        end
    end

    assign tensor_ram_re   = (state == S_STREAM);
    assign weight_rom_re   = (state == S_STREAM);
    assign bias_rom_re     = (state == S_BIAS);
    assign tensor_ram_addr = t_addr;
    assign weight_rom_addr = w_addr;
    assign bias_rom_addr   = group;

    assign out_valid   = (state == S_EMIT);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign out_channel = chan_base + CW'(lane);
    assign out_data    = (relu_q && acc[lane][31]) ? '0 : acc[lane];

endmodule

// File: tb/tb_dense_layer_parallel.sv
// Bench for dense_layer_parallel: ROM/RAM models, behavioural expectation queue,
// per-cycle monitor, directed cases plus randomized layers.
module tb_dense_layer_parallel;

    localparam int LANES = 4;
    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         relu_en = 1'b0;
    logic [8:0]   input_size = '0;
    logic [6:0]   output_size = '0;
    logic [7:0]   tensor_ram_addr;
    logic         tensor_ram_re;
    logic [7:0]   tensor_ram_dout = '0;
    logic [11:0]  weight_rom_addr;
    logic         weight_rom_re;
    logic [31:0]  weight_rom_dout = '0;
    logic [3:0]   bias_rom_addr;
    logic         bias_rom_re;
    logic [127:0] bias_rom_dout = '0;
    logic [31:0]  out_data;
    logic [5:0]   out_channel;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         done;

    dense_layer_parallel dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .relu_en(relu_en),
        .input_size(input_size),
        .output_size(output_size),
        .tensor_ram_addr(tensor_ram_addr),
        .tensor_ram_re(tensor_ram_re),
        .tensor_ram_dout(tensor_ram_dout),
        .weight_rom_addr(weight_rom_addr),
        .weight_rom_re(weight_rom_re),
        .weight_rom_dout(weight_rom_dout),
        .bias_rom_addr(bias_rom_addr),
        .bias_rom_re(bias_rom_re),
        .bias_rom_dout(bias_rom_dout),
        .out_data(out_data),
        .out_channel(out_channel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0]   tmem [256];
    logic [31:0]  wmem [4096];
    logic [127:0] bmem [16];

    always @(posedge clk) begin
        if (tensor_ram_re) tensor_ram_dout <= tmem[tensor_ram_addr];
        if (weight_rom_re) weight_rom_dout <= wmem[weight_rom_addr];
        if (bias_rom_re) bias_rom_dout <= bmem[bias_rom_addr];
    end

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int rmode = 0;
    int hold = 0;

    always @(posedge clk) begin
        #1;
        case (rmode)
            1: out_ready = ($urandom % 3) != 0;
            2: begin
                if (out_valid && out_channel == 6'd1 && hold < 5) begin
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = 1'b1;
        endcase
    end

    int exp_ch[$];
    int exp_dat[$];
    int beats = 0;
    int t_reads = 0;
    int b_reads = 0;
    bit stall = 0;
    logic [31:0] prev_d;
    logic [5:0]  prev_c;

    always @(negedge clk) begin
        if (reset) begin
            if (stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_d);
                chk("hold_channel", out_channel, prev_c);
            end
            if (!busy) begin
                chk("idle_strobes",
                    {tensor_ram_re, weight_rom_re, bias_rom_re, out_valid}, 0);
            end
            if (tensor_ram_re) t_reads++;
            if (bias_rom_re) b_reads++;
            if (out_valid) begin
                if (exp_ch.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    chk("beat_channel", out_channel, exp_ch[0]);
                    chk("beat_data", $signed(out_data), exp_dat[0]);
                    if (out_ready) begin
                        void'(exp_ch.pop_front());
                        void'(exp_dat.pop_front());
                        beats++;
                    end
                end
            end
            stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_c = out_channel;
        end else begin
            stall = 0;
        end
    end

    // Reference: each channel is its bias plus the int8 dot product, 32-bit wrap.
    task automatic build_expect(input int n_in, input int n_out, input bit relu);
        int g;
        int l;
        int sum;
        logic [31:0] bw;
        logic [7:0] xb;
        logic [7:0] wb;
        exp_ch.delete();
        exp_dat.delete();
        if (n_in == 0 || n_out == 0) return;
        for (int c = 0; c < n_out; c++) begin
            g = c / LANES;
            l = c % LANES;
            bw = bmem[g][32*l +: 32];
            sum = $signed(bw);
            for (int i = 0; i < n_in; i++) begin
                xb = tmem[i];
                wb = wmem[g*n_in + i][8*l +: 8];
                sum += int'($signed(xb)) * int'($signed(wb));
            end
            if (relu && sum < 0) sum = 0;
            exp_ch.push_back(c);
            exp_dat.push_back(sum);
        end
    endtask

    task automatic run_layer(input int n_in, input int n_out, input bit relu,
                             input int mode, input string tag);
        int groups;
        int n_eff;
        int cyc;
        groups = (n_in == 0 || n_out == 0) ? 0 : (n_out + LANES - 1) / LANES;
        n_eff = (groups == 0) ? 0 : n_out;
        rmode = mode;
        hold = 0;
        beats = 0;
        t_reads = 0;
        b_reads = 0;
        @(negedge clk);
        input_size = 9'(n_in);
        output_size = 7'(n_out);
        relu_en = relu;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        input_size = 9'($urandom);
        output_size = 7'($urandom);
        relu_en = 1'($urandom);
        cyc = 2;
        while (1) begin
            if (done) break;
            if (cyc >= LIMIT) begin
                chk({tag, "_timeout"}, 1, 0);
                break;
            end
            chk({tag, "_busy"}, busy, 1);
            @(negedge clk);
            cyc++;
        end
        if (mode == 0) chk({tag, "_latency"}, cyc, 2 + groups*(n_in + 2) + n_eff);
        chk({tag, "_beats"}, beats, n_eff);
        chk({tag, "_tensor_reads"}, t_reads, groups * n_in);
        chk({tag, "_bias_reads"}, b_reads, groups);
        chk({tag, "_leftover"}, exp_ch.size(), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        rmode = 0;
    endtask

    task automatic load_basic(input int b2);
        for (int i = 0; i < 4; i++) begin
            tmem[i] = 8'(i + 1);
            wmem[i] = 32'h01010101;
        end
        bmem[0] = {32'd100, 32'(b2), 32'd10, 32'd0};
    endtask

    task automatic pin(input string tag, input int a0, input int a1,
                       input int a2, input int a3);
        int lit[4];
        lit = '{a0, a1, a2, a3};
        chk({tag, "_model_size"}, exp_dat.size(), 4);
        for (int k = 0; k < 4 && k < exp_dat.size(); k++) begin
            chk({tag, "_model"}, exp_dat[k], lit[k]);
        end
    endtask

    initial begin
        int ni;
        int no;
        bit rl;
        for (int i = 0; i < 256; i++) tmem[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) wmem[i] = $urandom;
        for (int i = 0; i < 16; i++) bmem[i] = {$urandom, $urandom, $urandom, $urandom};

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_strobes", {tensor_ram_re, weight_rom_re, bias_rom_re}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_channel", out_channel, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        load_basic(-10);
        build_expect(4, 4, 0);
        pin("basic", 10, 20, 0, 110);
        run_layer(4, 4, 0, 0, "basic");

        load_basic(-20);
        build_expect(4, 4, 1);
        pin("relu", 10, 20, 0, 110);
        run_layer(4, 4, 1, 0, "relu");

        load_basic(-10);
        build_expect(4, 4, 0);
        run_layer(4, 4, 0, 2, "stall");
        chk("stall_cycles", hold, 5);

        for (int i = 0; i < 3; i++) tmem[i] = 8'h80;
        for (int i = 0; i < 6; i++) wmem[i] = 32'h80808080;
        bmem[0] = '0;
        bmem[1] = '0;
        build_expect(3, 6, 0);
        chk("neg_model_size", exp_dat.size(), 6);
        chk("neg_model_ch5", exp_dat[5], 49152);
        run_layer(3, 6, 0, 0, "neg");

        build_expect(0, 4, 0);
        run_layer(0, 4, 0, 0, "zero_in");
        build_expect(4, 0, 0);
        run_layer(4, 0, 0, 0, "zero_out");

        load_basic(-10);
        build_expect(4, 4, 0);
        @(negedge clk);
        input_size = 9'd4;
        output_size = 7'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !tensor_ram_re; k++) @(negedge clk);
        chk("mid_reach_stream", tensor_ram_re, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_strobes", {tensor_ram_re, weight_rom_re, bias_rom_re}, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_channel", out_channel, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        build_expect(4, 4, 0);
        pin("restart", 10, 20, 0, 110);
        run_layer(4, 4, 0, 0, "restart");

        for (int i = 0; i < 256; i++) tmem[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) wmem[i] = $urandom;
        for (int i = 0; i < 16; i++) bmem[i] = {$urandom, $urandom, $urandom, $urandom};

        build_expect(256, 8, 0);
        run_layer(256, 8, 0, 0, "max_in");
        build_expect(7, 64, 1);
        run_layer(7, 64, 1, 1, "max_out");
        build_expect(5, 5, 0);
        run_layer(5, 5, 0, 0, "partial");
        for (int t = 0; t < 8; t++) begin
            ni = $urandom_range(1, 24);
            no = $urandom_range(1, 24);
            rl = 1'($urandom);
            build_expect(ni, no, rl);
            run_layer(ni, no, rl, (t % 2 == 0) ? 1 : 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dense_layer_parallel.md
DENSE_LAYER_PARALLEL -- requirements
Module: dense_layer_parallel

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
 - MAX_IN, 256: maximum input vector length.
 - MAX_OUT, 64: maximum output channel count.
 - LANES, 4: MAC lanes computed in parallel; power of 2, divides MAX_OUT.
REQ-002 SHALL provide ports (name direction width meaning):
 - clk  in  1  single clock; all logic on rising edge.
 - reset  in  1  asynchronous, active-low reset.
 - start  in  1  request a layer computation; sampled only in IDLE.
 - relu_en  in  1  clamp negative results to 0; latched at start.
 - input_size  in  clog2(MAX_IN+1)  vector length, 0..MAX_IN; latched at start.
 - output_size  in  clog2(MAX_OUT+1)  channel count, 0..MAX_OUT; latched at start.
 - tensor_ram_addr  out  clog2(MAX_IN)  input element index.
 - tensor_ram_re  out  1  tensor read strobe; data valid the following cycle.
 - tensor_ram_dout  in  8  signed int8 input element.
 - weight_rom_addr  out  clog2(MAX_IN*MAX_OUT/LANES)  = group*input_size + i.
 - weight_rom_re  out  1  weight read strobe; 1-cycle latency.
 - weight_rom_dout  in  8*LANES  byte l = int8 weight for channel group*LANES+l.
 - bias_rom_addr  out  clog2(MAX_OUT/LANES)  group index.
 - bias_rom_re  out  1  bias read strobe; 1-cycle latency.
 - bias_rom_dout  in  32*LANES  word l = int32 bias for channel group*LANES+l.
 - out_data  out  32  result for out_channel.
 - out_channel  out  clog2(MAX_OUT)  channel index of out_data.
 - out_valid  out  1  out_data/out_channel valid.
 - out_ready  in  1  downstream accepts beat when out_valid && out_ready.
 - busy  out  1  high in every state except IDLE.
 - done  out  1  one-cycle pulse at end of layer.

Function
REQ-003 States SHALL be IDLE, BIAS, STREAM, DRAIN, EMIT, DONE.
REQ-004 IDLE->BIAS on start with both sizes nonzero; start with either size 0 SHALL go IDLE->DONE, no reads and no outputs; start outside IDLE SHALL be ignored.
REQ-005 BIAS: one cycle, bias_rom_re=1, bias_rom_addr=group; ->STREAM.
REQ-006 STREAM: one read per cycle, tensor_ram_re=weight_rom_re=1, i=0..input_size-1, no gaps; after issuing i=input_size-1 ->DRAIN.
REQ-007 First STREAM cycle SHALL load each lane accumulator with its bias word; the cycle after issuing read i SHALL add tensor(i)*weight_l(i) to lane l.
REQ-008 DRAIN: one cycle, performs final MAC, no reads; ->EMIT.
REQ-009 Products SHALL be signed 8x8->16, sign-extended to 32; accumulators 32-bit signed, two's-complement wrap, no saturation.
REQ-010 EMIT SHALL present lanes in ascending order, one beat per lane; active lanes = min(LANES, output_size - group*LANES); inactive lanes never emitted.
REQ-011 out_data/out_channel SHALL hold stable while out_valid && !out_ready; advance only on handshake.
REQ-012 relu_en latched 1 SHALL output 0 for negative accumulators; otherwise raw value.
REQ-013 After last active lane's handshake: more groups -> BIAS with group+1; else ->DONE.
REQ-014 DONE: done=1 for exactly one cycle; ->IDLE.
REQ-015 Read strobes SHALL be 0 outside BIAS/STREAM; addresses hold previous value otherwise.
REQ-016 Layer latency with out_ready=1: 1 + groups*(input_size + 2 + active_lanes) + 1 cycles from start to done.

Reset
REQ-017 reset low SHALL immediately force IDLE; out_valid, done, busy, all read strobes, out_data, out_channel, counters, accumulators = 0.
REQ-018 Reset mid-layer SHALL abandon computation; first start after release begins fresh from group 0.

Verification
REQ-019 in=4, out=4, LANES=4, x={1,2,3,4}, W rows all 1, bias={0,10,-10,100}, ready=1 -> channels 0..3 = {10,20,0,110}; done at cycle 12.
REQ-020 in=3, out=6 (group 1 partial), x={-128,-128,-128}, weights -128, bias 0 -> all 6 outputs 49152; exactly 6 beats, channels 0..5.
REQ-021 Same as REQ-019 with relu_en=1, bias[2]=-20 -> channel 2 = -10 clamped to 0, others unchanged.
REQ-022 out_ready held low 5 cycles during EMIT of channel 1 -> out_data/out_channel stable, no beat lost or duplicated.
REQ-023 start with input_size=0 -> no strobes, no out_valid, done pulse 2 cycles after start.
REQ-024 reset asserted during STREAM of group 0, restart with REQ-019 stimulus -> REQ-019 results exactly.
